uart_cfg_seq: RTL and testbench

UART_CFG_SEQ -- requirements
Module: uart_cfg_seq

---
 rtl/uart_cfg_seq.sv | 129 ++++++++++++
 tb/tb_uart_cfg_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_seq.sv
// Programs a 16550-style UART (LCR/DLAB, DLL, DLM, LCR, FCR, optional LCR read-back) from one start pulse.
// Latency: 5 writes at N+1..N+5, done_o at N+8 (verify) or N+6; start_i is dropped unless idle, no backpressure.
module uart_cfg_seq #(
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] divisor_i,
  input  logic [6:0]  lcr_i,
  input  logic [7:0]  fcr_i,
  output logic        wr_o,
  output logic        rd_o,
  output logic [2:0]  addr_o,
  output logic [7:0]  dout_o,
  input  logic [7:0]  din_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    IDLE, W_LCRD, W_DLL, W_DLM, W_LCR, W_FCR, R_LCR, CHK, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [6:0]  lcr_q, lcr_d;
  logic [7:0]  fcr_q, fcr_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lcr_d   = lcr_q;
    fcr_d   = fcr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisor_i != 16'd0) begin
            div_d   = divisor_i;
            lcr_d   = lcr_i;
            fcr_d   = fcr_i;
            err_d   = 1'b0;
            state_d = W_LCRD;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      W_LCRD:  state_d = W_DLL;
      W_DLL:   state_d = W_DLM;
      W_DLM:   state_d = W_LCR;
      W_LCR:   state_d = W_FCR;
      W_FCR:   state_d = VERIFY_EN ? R_LCR : DONE;
      R_LCR:   state_d = CHK;
      CHK: begin
        if (din_i != {1'b0, lcr_q}) err_d = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each strobe lands in the cycle its state occupies.
  always_comb begin
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    addr_d = 3'd0;
    dout_d = 8'd0;
    unique case (state_d)
      W_LCRD: begin wr_d = 1'b1; addr_d = 3'd3; dout_d = {1'b1, lcr_d}; end
      W_DLL:  begin wr_d = 1'b1; addr_d = 3'd0; dout_d = div_d[7:0];    end
      W_DLM:  begin wr_d = 1'b1; addr_d = 3'd1; dout_d = div_d[15:8];   end
      W_LCR:  begin wr_d = 1'b1; addr_d = 3'd3; dout_d = {1'b0, lcr_d}; end
      W_FCR:  begin wr_d = 1'b1; addr_d = 3'd2; dout_d = fcr_d;         end
      R_LCR:  begin rd_d = 1'b1; addr_d = 3'd3;                         end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 16'd0;
      lcr_q   <= 7'd0;
      fcr_q   <= 8'd0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 3'd0;
      dout_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lcr_q   <= lcr_d;
      fcr_q   <= fcr_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_o   = wr_q;
  assign rd_o   = rd_q;
  assign addr_o = addr_q;
  assign dout_o = dout_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_uart_cfg_seq.sv
// Directed bench for uart_cfg_seq: one instance with read-back, one without.
module tb_uart_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        st1, st0;
  logic [15:0] div_i;
  logic [6:0]  lcr_i;
  logic [7:0]  fcr_i;
  logic [7:0]  ret_val;
  logic [7:0]  din1, din0;

  logic       wr1, rd1, busy1, done1, err1;
  logic [2:0] addr1;
  logic [7:0] dout1;
  logic       wr0, rd0, busy0, done0, err0;
  logic [2:0] addr0;
  logic [7:0] dout0;

  logic [14:0] pack1, pack0;
  assign pack1 = {wr1, rd1, addr1, dout1, busy1, done1};
  assign pack0 = {wr0, rd0, addr0, dout0, busy0, done0};

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt, rd_cnt, done_cnt;
  logic [10:0] errs;

  always #5 clk = ~clk;

  uart_cfg_seq #(.VERIFY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start_i(st1), .divisor_i(div_i), .lcr_i(lcr_i), .fcr_i(fcr_i),
    .wr_o(wr1), .rd_o(rd1), .addr_o(addr1), .dout_o(dout1), .din_i(din1),
    .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  uart_cfg_seq #(.VERIFY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start_i(st0), .divisor_i(div_i), .lcr_i(lcr_i), .fcr_i(fcr_i),
    .wr_o(wr0), .rd_o(rd0), .addr_o(addr0), .dout_o(dout0), .din_i(din0),
    .busy_o(busy0), .done_o(done0), .err_o(err0)
  );

  // Register-file model: read data appears the cycle after rd_o, zero otherwise.
  always @(posedge clk) begin
    din1 <= rd1 ? ret_val : 8'h00;
    din0 <= rd0 ? ret_val : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {wr,rd,addr,dout,busy,done} for cycle N+k of a sequence started at edge N.
  function automatic logic [14:0] exp_vec(input int k, input bit ver, input logic [15:0] div,
                                          input logic [6:0] lcr, input logic [7:0] fcr,
                                          input int rst_at);
    logic [14:0] v;
    v = 15'd0;
    if (rst_at != 0 && k > rst_at) return v;
    if (div == 16'd0) begin
      if (k == 1) v = {1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1};
      return v;
    end
    case (k)
      1: v = {1'b1, 1'b0, 3'd3, {1'b1, lcr}, 1'b1, 1'b0};
      2: v = {1'b1, 1'b0, 3'd0, div[7:0],    1'b1, 1'b0};
      3: v = {1'b1, 1'b0, 3'd1, div[15:8],   1'b1, 1'b0};
      4: v = {1'b1, 1'b0, 3'd3, {1'b0, lcr}, 1'b1, 1'b0};
      5: v = {1'b1, 1'b0, 3'd2, fcr,         1'b1, 1'b0};
      6: v = ver ? {1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 1'b0} : {1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1};
      7: v = ver ? {1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0} : 15'd0;
      8: v = ver ? {1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1} : 15'd0;
      default: v = 15'd0;
    endcase
    return v;
  endfunction

  task automatic run(input bit sel, input logic [15:0] div, input logic [6:0] lcr,
                     input logic [7:0] fcr, input logic [7:0] ret, input logic [15:0] smask,
                     input int rst_at, input string name);
    logic [14:0] got;
    ret_val = ret;
    div_i = div;
    lcr_i = lcr;
    fcr_i = fcr;
    if (sel) st1 = 1'b1; else st0 = 1'b1;
    tick();
    st1 = 1'b0;
    st0 = 1'b0;
    // Scramble inputs: the sequence must use only the values latched at start.
    div_i = ~div;
    lcr_i = ~lcr;
    fcr_i = ~fcr;
    wr_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    errs = '0;
    for (int k = 1; k <= 10; k++) begin
      if (sel) st1 = smask[k]; else st0 = smask[k];
      rst = (k == rst_at);
      got = sel ? pack1 : pack0;
      check($sformatf("%s_c%0d", name, k), {17'd0, got}, {17'd0, exp_vec(k, sel, div, lcr, fcr, rst_at)});
      errs[k]  = sel ? err1 : err0;
      wr_cnt   += int'(got[14]);
      rd_cnt   += int'(got[13]);
      done_cnt += int'(got[0]);
      tick();
    end
    st1 = 1'b0;
    st0 = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    st1 = 1'b0;
    st0 = 1'b0;
    div_i = 16'h0;
    lcr_i = 7'h0;
    fcr_i = 8'h0;
    ret_val = 8'h00;
    tick();
    tick();
    check("reset_out1", {16'd0, pack1, err1}, 32'd0);
    check("reset_out0", {16'd0, pack0, err0}, 32'd0);
    rst = 1'b0;
    tick();

    // Nominal programming, read-back matches.
    run(1'b1, 16'h0108, 7'h03, 8'hC7, 8'h03, 16'h0, 0, "cfg_ok");
    check("cfg_ok_err_done", {31'd0, errs[8]}, 32'd0);
    check("cfg_ok_wr_cnt", wr_cnt, 32'd5);
    check("cfg_ok_rd_cnt", rd_cnt, 32'd1);

    // Read-back returns DLAB still set.
    run(1'b1, 16'h0108, 7'h03, 8'hC7, 8'h83, 16'h0, 0, "cfg_bad");
    check("cfg_bad_err_done", {31'd0, errs[8]}, 32'd1);
    check("cfg_bad_err_after", {31'd0, errs[10]}, 32'd1);
    tick();
    tick();
    check("cfg_bad_err_hold", {31'd0, err1}, 32'd1);

    // Zero divisor: no accesses, immediate done with error.
    run(1'b1, 16'h0000, 7'h03, 8'hC7, 8'h03, 16'h0, 0, "div0");
    check("div0_err_done", {31'd0, errs[1]}, 32'd1);
    check("div0_err_hold", {31'd0, errs[3]}, 32'd1);
    check("div0_wr_cnt", wr_cnt + rd_cnt, 32'd0);

    // Start pulses mid-sequence and in the done cycle are ignored.
    run(1'b1, 16'h0108, 7'h03, 8'hC7, 8'h03, 16'h0108, 0, "restart");
    check("restart_err_clr", {31'd0, errs[1]}, 32'd0);
    check("restart_wr_cnt", wr_cnt, 32'd5);
    check("restart_done_cnt", done_cnt, 32'd1);

    // Reset beats a simultaneous start.
    run(1'b1, 16'h0000, 7'h03, 8'hC7, 8'h03, 16'h0, 0, "pre_prio");
    rst = 1'b1;
    st1 = 1'b1;
    div_i = 16'h0108;
    tick();
    check("rst_prio_out", {16'd0, pack1, err1}, 32'd0);
    rst = 1'b0;
    st1 = 1'b0;
    tick();
    check("rst_prio_idle", {16'd0, pack1, err1}, 32'd0);

    // Reset during the DLM write aborts, then a fresh start replays everything.
    run(1'b1, 16'h0108, 7'h03, 8'hC7, 8'h03, 16'h0, 3, "abort");
    check("abort_done_cnt", done_cnt, 32'd0);
    check("abort_err", {31'd0, errs[4]}, 32'd0);
    run(1'b1, 16'h0108, 7'h03, 8'hC7, 8'h03, 16'h0, 0, "replay");
    check("replay_wr_cnt", wr_cnt, 32'd5);

    // No read-back variant, full-scale divisor.
    run(1'b0, 16'hFFFF, 7'h03, 8'h01, 8'h00, 16'h0, 0, "nover");
    check("nover_rd_cnt", rd_cnt, 32'd0);
    check("nover_done_cnt", done_cnt, 32'd1);
    check("nover_err", {31'd0, errs[6]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
